axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 64, data width; strobe width DW/8.
REQ-003 SHALL have parameter DEPTH, default 16, number of DW-wide words, power of two.
REQ-004 SHALL have port axi_aclk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports axi_awaddr in AW, axi_awlen in 8, axi_awburst in 2: write address, beats-1, burst type.
REQ-007 SHALL have ports axi_awvalid in 1 and axi_awready out 1: AW handshake.
REQ-008 SHALL have ports axi_wdata in DW, axi_wstrb in DW/8, axi_wlast in 1: write beat data, byte strobes, last flag.
REQ-009 SHALL have ports axi_wvalid in 1 and axi_wready out 1: W handshake.
REQ-010 SHALL have ports axi_bresp out 2, axi_bvalid out 1, axi_bready in 1: write response.
REQ-011 SHALL have ports axi_araddr in AW, axi_arlen in 8, axi_arburst in 2: read address, beats-1, burst type.
REQ-012 SHALL have ports axi_arvalid in 1 and axi_arready out 1: AR handshake.
REQ-013 SHALL have ports axi_rdata out DW, axi_rresp out 2, axi_rlast out 1, axi_rvalid out 1, axi_rready in 1: read data channel.

Function
REQ-014 SHALL respond as AXI4 slave to one write and one read burst at a time; write and read paths independent and concurrent.
REQ-015 SHALL form word index = addr[3+log2(DEPTH)-1:3]; upper and low 3 bits ignored; every transfer is full DW width.
REQ-016 SHALL treat burst 2'b00 FIXED (index held), 2'b01 INCR (index+1 per beat, wraps DEPTH-1 -> 0); 2'b10/2'b11 unsupported.
REQ-017 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-018 W_IDLE: on awvalid&&awready, latch index, awlen, awburst, clear beat count and error flag, go W_DATA next cycle.
REQ-019 W_DATA: each wvalid&&wready beat writes byte lanes with wstrb=1 to mem[index], others unchanged; wstrb=0 beat accepted, no write.
REQ-020 Burst SHALL end on beat with count==awlen regardless of wlast; error flag set if wlast != (count==awlen) on any beat.
REQ-021 Unsupported burst: beats accepted, no memory write, error flag set.
REQ-022 After last beat go W_RESP; bresp=2'b10 if error flag else 2'b00; bvalid/bresp held stable until bready; then W_IDLE next cycle.
REQ-023 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-024 On arvalid&&arready, latch index, arlen, arburst; next cycle rvalid=1, rdata=mem[index] registered at the handshake edge.
REQ-025 rdata, rresp, rlast SHALL be held stable while rvalid&&!rready.
REQ-026 On each rvalid&&rready, advance index per burst type and load next word; rlast=1 exactly on beat count==arlen; after last handshake R_IDLE, rvalid=0 next cycle.
REQ-027 Unsupported read burst: arlen+1 beats returned with rdata=0, rresp=2'b10; otherwise rresp=2'b00.
REQ-028 Write and read to same index in same cycle: read loads pre-write contents; write visible to loads on later edges.
REQ-029 Back-to-back: new AW accepted no earlier than cycle after B handshake; new AR no earlier than cycle after final R handshake.

Reset
REQ-030 While rst=1: awready=1, arready=1, wready=0, bvalid=0, bresp=0, rvalid=0, rlast=0, rresp=0, rdata=0, FSMs in IDLE, all memory words 0.
REQ-031 Reset asserted mid-burst SHALL abandon both bursts immediately; no response issued for them after release.

Verification
REQ-032 Reset, then AR addr 0x0 len 0 INCR -> one beat rdata=0, rresp=00, rlast=1.
REQ-033 AW addr 0x8 len 3 INCR, W beats 0x11..0x44 strb 0xFF, wlast on beat 4 -> bresp=00; read len 3 from 0x8 returns 0x11,0x22,0x33,0x44, rlast on 4th.
REQ-034 INCR write len 1 at addr 0x78 (index 15) -> second beat lands at index 0; read back confirms wrap.
REQ-035 Write len 2 with wlast on beat 2 -> burst still 3 beats, bresp=10; wstrb=0x0F beat updates low 4 bytes only.
REQ-036 Read len 3 with rready toggling 1-0-0-1 and bready held 0 for 5 cycles -> rdata/rlast/bvalid/bresp stable throughout stalls, no beat lost or repeated.
REQ-037 AR burst 2'b10 len 1 -> two beats rdata=0, rresp=10; rst pulse mid-write -> awready=1, bvalid=0, memory cleared.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a small register-file memory.
//
// One write burst and one read burst may be in flight at a time, on independent
// FSMs. Word index is addr[3 +: log2(DEPTH)]; every beat is a full DW-wide word.
// FIXED and INCR bursts are supported (INCR wraps at DEPTH-1 -> 0); WRAP and the
// reserved burst encoding are answered with SLVERR and never touch memory.
//
// Ports:
//   axi_aclk, rst                       clock, asynchronous active-high reset
//   axi_aw{addr,len,burst,valid,ready}  write address channel
//   axi_w{data,strb,last,valid,ready}   write data channel
//   axi_b{resp,valid,ready}             write response channel
//   axi_ar{addr,len,burst,valid,ready}  read address channel
//   axi_r{data,resp,last,valid,ready}   read data channel
module axi_slave_mem #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic            axi_aclk,
    input  logic            rst,
    input  logic [AW-1:0]   axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [1:0]      axi_awburst,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [DW-1:0]   axi_wdata,
    input  logic [DW/8-1:0] axi_wstrb,
    input  logic            axi_wlast,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    output logic [1:0]      axi_bresp,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    input  logic [AW-1:0]   axi_araddr,
    input  logic [7:0]      axi_arlen,
    input  logic [1:0]      axi_arburst,
    input  logic            axi_arvalid,
    output logic            axi_arready,
    output logic [DW-1:0]   axi_rdata,
    output logic [1:0]      axi_rresp,
    output logic            axi_rlast,
    output logic            axi_rvalid,
    input  logic            axi_rready
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{axi_awaddr, axi_araddr};

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_e      w_state_q, w_state_d;
    logic [IW-1:0] w_idx_q, w_idx_d;
    logic [7:0]    w_len_q, w_len_d;
    logic [1:0]    w_burst_q, w_burst_d;
    logic [7:0]    w_cnt_q, w_cnt_d;
    logic          w_err_q, w_err_d;
    logic          w_last_beat;
    logic          w_burst_ok;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_burst_ok  = ~w_burst_q[1];

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid) begin
                    w_idx_d   = axi_awaddr[3 +: IW];
                    w_len_d   = axi_awlen;
                    w_burst_d = axi_awburst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid) begin
                    mem_we = w_burst_ok;
                    // Beat count, not wlast, terminates the burst; a disagreeing
                    // wlast only poisons the response.
                    if (!w_burst_ok || (axi_wlast != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (w_burst_q == BurstIncr) begin
                            w_idx_d = IW'(w_idx_q + 1'b1);
                        end
                    end
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    assign axi_awready = (w_state_q == W_IDLE);
    assign axi_wready  = (w_state_q == W_DATA);
    assign axi_bvalid  = (w_state_q == W_RESP);
    assign axi_bresp   = (axi_bvalid && w_err_q) ? RespSlvErr : RespOkay;

    // ------------------------------------------------------------------
    // Memory: byte-lane writes; reads see pre-write contents on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (axi_wstrb[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_e      r_state_q, r_state_d;
    logic [IW-1:0] r_idx_q, r_idx_d;
    logic [7:0]    r_len_q, r_len_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rlast_q, rlast_d;
    logic [IW-1:0] r_idx_next;
    logic [7:0]    r_cnt_inc;
    logic [IW-1:0] ar_idx;
    logic          ar_burst_ok;

    assign ar_idx      = axi_araddr[3 +: IW];
    assign ar_burst_ok = ~axi_arburst[1];
    assign r_cnt_inc   = r_cnt_q + 8'd1;
    assign r_idx_next  = (r_burst_q == BurstIncr) ? IW'(r_idx_q + 1'b1) : r_idx_q;

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid) begin
                    r_idx_d   = ar_idx;
                    r_len_d   = axi_arlen;
                    r_burst_d = axi_arburst;
                    r_cnt_d   = 8'd0;
                    rdata_d   = ar_burst_ok ? mem_q[ar_idx] : '0;
                    rresp_d   = ar_burst_ok ? RespOkay : RespSlvErr;
                    rlast_d   = (axi_arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    if (r_cnt_q == r_len_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_inc;
                        r_idx_d = r_idx_next;
                        // rresp was latched at AR time and encodes support.
                        rdata_d = (rresp_q == RespOkay) ? mem_q[r_idx_next] : '0;
                        rlast_d = (r_cnt_inc == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign axi_arready = (r_state_q == R_IDLE);
    assign axi_rvalid  = (r_state_q == R_DATA);
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = axi_rvalid ? rresp_q : RespOkay;
    assign axi_rlast   = axi_rvalid & rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed self-checking bench for axi_slave_mem.
module tb_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    axi_slave_mem #(.AW(32), .DW(64), .DEPTH(16)) dut (
        .axi_aclk    (clk),
        .rst         (rst),
        .axi_awaddr  (awaddr),
        .axi_awlen   (awlen),
        .axi_awburst (awburst),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wlast   (wlast),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arlen   (arlen),
        .axi_arburst (arburst),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rlast   (rlast),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready)
    );

    // ---------------- channel drivers (stimulus only) ----------------
    // All drivers run at #1 after a rising edge; a handshake completes on the
    // next rising edge if valid and ready were both high before it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bt);
        awaddr = a; awlen = l; awburst = bt; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (awready) begin
                step();
                awvalid = 1'b0;
                return;
            end
            step();
        end
        awvalid = 1'b0;
        checks++;
        $display("FAIL aw_timeout: awready=0 after 50 cycles, required 1");
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (wready) begin
                step();
                wvalid = 1'b0;
                wlast = 1'b0;
                return;
            end
            step();
        end
        wvalid = 1'b0;
        checks++;
        $display("FAIL w_timeout: wready=0 after 50 cycles, required 1");
    endtask

    task automatic do_b(output logic [1:0] resp);
        bready = 1'b1;
        resp = 2'bxx;
        for (int i = 0; i < 50; i++) begin
            if (bvalid) begin
                resp = bresp;
                step();
                bready = 1'b0;
                return;
            end
            step();
        end
        bready = 1'b0;
        checks++;
        $display("FAIL b_timeout: bvalid=0 after 50 cycles, required 1");
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bt);
        araddr = a; arlen = l; arburst = bt; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (arready) begin
                step();
                arvalid = 1'b0;
                return;
            end
            step();
        end
        arvalid = 1'b0;
        checks++;
        $display("FAIL ar_timeout: arready=0 after 50 cycles, required 1");
    endtask

    task automatic do_r(output logic [63:0] d, output logic [1:0] resp, output logic last);
        rready = 1'b1;
        d = 'x; resp = 'x; last = 1'bx;
        for (int i = 0; i < 50; i++) begin
            if (rvalid) begin
                d = rdata; resp = rresp; last = rlast;
                step();
                rready = 1'b0;
                return;
            end
            step();
        end
        rready = 1'b0;
        checks++;
        $display("FAIL r_timeout: rvalid=0 after 50 cycles, required 1");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1;
        repeat (3) step();
        obs = {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp};
        checks++;
        if (obs !== 10'b11_0_0_00_0_0_00)
            $display("FAIL reset_ctrl: got %b want %b", obs, 10'b11_0_0_00_0_0_00);
        else passed++;
        checks++;
        if (rdata !== 64'd0) $display("FAIL reset_rdata: got %h want 0", rdata);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_zero();
        logic [63:0] d; logic [1:0] rs; logic l;
        do_ar(32'h0, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if ({d, rs, l} !== {64'd0, 2'b00, 1'b1})
            $display("FAIL read_zero: got d=%h resp=%b last=%b want 0/00/1", d, rs, l);
        else passed++;
        checks++;
        if ({rvalid, arready} !== 2'b01)
            $display("FAIL read_zero_end: rvalid,arready=%b want 01", {rvalid, arready});
        else passed++;
    endtask

    task automatic test_incr();
        logic [63:0] d; logic [1:0] rs; logic l;
        do_aw(32'h8, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(64'(17 * (i + 1)), 8'hFF, (i == 3));
        do_b(rs);
        checks++;
        if (rs !== 2'b00) $display("FAIL incr_bresp: got %b want 00", rs);
        else passed++;
        do_ar(32'h8, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            do_r(d, rs, l);
            checks++;
            if ({d, rs, l} !== {64'(17 * (i + 1)), 2'b00, (i == 3)})
                $display("FAIL incr_beat%0d: got d=%h resp=%b last=%b want d=%h resp=00 last=%b",
                         i, d, rs, l, 64'(17 * (i + 1)), (i == 3));
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d; logic [1:0] rs; logic l;
        logic [63:0] exp [3];
        exp[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        exp[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        exp[2] = 64'hBBBB_BBBB_BBBB_BBBB;
        do_aw(32'h78, 8'd1, 2'b01);
        do_w(exp[0], 8'hFF, 1'b0);
        do_w(exp[1], 8'hFF, 1'b1);
        do_b(rs);
        checks++;
        if (rs !== 2'b00) $display("FAIL wrap_bresp: got %b want 00", rs);
        else passed++;
        do_ar(32'h78, 8'd1, 2'b01);
        for (int i = 0; i < 2; i++) begin
            do_r(d, rs, l);
            checks++;
            if ({d, l} !== {exp[i], (i == 1)})
                $display("FAIL wrap_rd%0d: got %h last=%b want %h", i, d, l, exp[i]);
            else passed++;
        end
        do_ar(32'h0, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== exp[2]) $display("FAIL wrap_idx0: got %h want %h", d, exp[2]);
        else passed++;
    endtask

    task automatic test_wlast_strb();
        logic [63:0] d; logic [1:0] rs; logic l;
        logic [63:0] exp [3];
        exp[0] = 64'h0101_0101_0101_0101;
        exp[1] = 64'h0202_0202_0202_0202;
        exp[2] = 64'h1111_2222_FFFF_FFFF;
        do_aw(32'h50, 8'd0, 2'b01);
        do_w(64'h1111_2222_3333_4444, 8'hFF, 1'b1);
        do_b(rs);
        do_aw(32'h40, 8'd2, 2'b01);
        do_w(exp[0], 8'hFF, 1'b0);
        do_w(exp[1], 8'hFF, 1'b1);          // early wlast
        do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
        checks++;
        if ({wready, bvalid} !== 2'b01)
            $display("FAIL wlast_end: wready,bvalid=%b want 01", {wready, bvalid});
        else passed++;
        do_b(rs);
        checks++;
        if (rs !== 2'b10) $display("FAIL wlast_bresp: got %b want 10", rs);
        else passed++;
        do_ar(32'h40, 8'd2, 2'b01);
        for (int i = 0; i < 3; i++) begin
            do_r(d, rs, l);
            checks++;
            if ({d, l} !== {exp[i], (i == 2)})
                $display("FAIL strb_rd%0d: got %h last=%b want %h", i, d, l, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [3:0]  pat = 4'b1001;         // rready 1,0,0,1 repeating
        logic [1:0]  rs;
        logic [63:0] prev_d = '0;
        logic        prev_l = 1'b0;
        logic        prev_rstall = 1'b0;
        logic        prev_bstall = 1'b0;
        int          nbeats = 0;
        logic        bdone = 1'b0;
        bready = 1'b0;
        do_aw(32'h60, 8'd0, 2'b01);
        do_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
        do_ar(32'h8, 8'd3, 2'b01);
        for (int c = 0; c < 40; c++) begin
            rready = pat[c % 4];
            bready = (c >= 5);
            if (c == 0) begin
                checks++;
                if ({bvalid, rvalid} !== 2'b11)
                    $display("FAIL stall_start: bvalid,rvalid=%b want 11", {bvalid, rvalid});
                else passed++;
            end
            if (prev_rstall) begin
                checks++;
                if ({rvalid, rdata, rlast} !== {1'b1, prev_d, prev_l})
                    $display("FAIL stall_r_hold c%0d: got v=%b d=%h l=%b want 1 %h %b",
                             c, rvalid, rdata, rlast, prev_d, prev_l);
                else passed++;
            end
            if (prev_bstall) begin
                checks++;
                if ({bvalid, bresp} !== 3'b100)
                    $display("FAIL stall_b_hold c%0d: got v=%b resp=%b want 1 00", c, bvalid, bresp);
                else passed++;
            end
            if (rvalid && rready) begin
                checks++;
                if ({rdata, rlast} !== {64'(17 * (nbeats + 1)), (nbeats == 3)})
                    $display("FAIL stall_beat%0d: got %h last=%b want %h", nbeats, rdata, rlast,
                             64'(17 * (nbeats + 1)));
                else passed++;
                nbeats++;
            end
            if (bvalid && bready) bdone = 1'b1;
            prev_rstall = rvalid && !rready;
            prev_bstall = bvalid && !bready;
            prev_d = rdata;
            prev_l = rlast;
            step();
            if (nbeats >= 4 && bdone) break;
        end
        rready = 1'b0;
        bready = 1'b0;
        rs = {rvalid, bvalid};
        checks++;
        if (nbeats != 4 || !bdone || rs !== 2'b00)
            $display("FAIL stall_end: beats=%0d bdone=%b rvalid,bvalid=%b want 4 1 00",
                     nbeats, bdone, rs);
        else passed++;
    endtask

    task automatic test_unsupported();
        logic [63:0] d; logic [1:0] rs; logic l;
        do_ar(32'h8, 8'd1, 2'b10);
        for (int i = 0; i < 2; i++) begin
            do_r(d, rs, l);
            checks++;
            if ({d, rs, l} !== {64'd0, 2'b10, (i == 1)})
                $display("FAIL unsup_rd%0d: got d=%h resp=%b last=%b want 0 10 %b",
                         i, d, rs, l, (i == 1));
            else passed++;
        end
        do_aw(32'h8, 8'd0, 2'b11);
        do_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
        do_b(rs);
        checks++;
        if (rs !== 2'b10) $display("FAIL unsup_bresp: got %b want 10", rs);
        else passed++;
        do_ar(32'h8, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== 64'h11) $display("FAIL unsup_nowrite: got %h want %h", d, 64'h11);
        else passed++;
    endtask

    task automatic test_fixed();
        logic [63:0] d; logic [1:0] rs; logic l;
        do_aw(32'h18, 8'd1, 2'b00);
        do_w(64'h7777_7777_7777_7777, 8'hFF, 1'b0);
        do_w(64'h9999_9999_9999_9999, 8'hFF, 1'b1);
        do_b(rs);
        do_ar(32'h18, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== 64'h9999_9999_9999_9999) $display("FAIL fixed_idx3: got %h want 9999..", d);
        else passed++;
        do_ar(32'h20, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== 64'h44) $display("FAIL fixed_idx4: got %h want %h", d, 64'h44);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic [1:0] rs; logic l;
        logic [4:0] obs;
        do_aw(32'h8, 8'd3, 2'b01);
        do_w(64'h1234, 8'hFF, 1'b0);
        do_ar(32'h8, 8'd3, 2'b01);
        rst = 1'b1;
        #1;
        obs = {awready, arready, wready, bvalid, rvalid};
        checks++;
        if (obs !== 5'b11000) $display("FAIL rstmid_ctrl: got %b want 11000", obs);
        else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bvalid, rvalid, wready} !== 3'b000)
                $display("FAIL rstmid_idle%0d: bvalid,rvalid,wready=%b want 000",
                         i, {bvalid, rvalid, wready});
            else passed++;
            step();
        end
        do_ar(32'h8, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== 64'd0) $display("FAIL rstmid_mem8: got %h want 0", d);
        else passed++;
        do_ar(32'h78, 8'd0, 2'b01);
        do_r(d, rs, l);
        checks++;
        if (d !== 64'd0) $display("FAIL rstmid_mem78: got %h want 0", d);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_read_zero();
        test_incr();
        test_wrap();
        test_wlast_strb();
        test_stall();
        test_unsupported();
        test_fixed();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
